// File: rtl/ch0re_ifetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package ch0re_ifetch_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  // addi x0,x0,0
  localparam logic [ILEN-1:0] CH0RE_NOP = 32'h00000013;

  typedef enum logic [1:0] {
    IF_BOOT,
    IF_RUN,
    IF_FLUSH
  } ifetch_state_e;

  // Force a byte address onto a 32-bit instruction boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/ch0re_ifetch_fifo.sv
// Small synchronous FIFO with flush; head is readable combinationally.
// Push and pop may coincide even when full.
module ch0re_fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy; flush wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop && !flush));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && empty && !flush));

endmodule

// File: rtl/ch0re_ifetch.sv
// Instruction-fetch stage: owns the PC, issues in-order word fetches,
// buffers responses and hands {instr, pc} to the decoder.
// Optional macro CH0RE_IFETCH_PERF_EN adds fetched/flushed event counters.
module ch0re_ifetch
  import ch0re_ifetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 64'h0,
  parameter int unsigned     FIFO_DEPTH = 2,
  parameter logic [ILEN-1:0] NOP_INSTR  = CH0RE_NOP
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [ILEN-1:0] i_imem_rdata,
  input  logic            i_stall,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_valid,
  output logic [ILEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc
`ifdef CH0RE_IFETCH_PERF_EN
  ,
  output logic [31:0]     o_perf_fetched,
  output logic [31:0]     o_perf_flushed
`endif
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  ifetch_state_e   state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] last_pc_q;
  logic [CNT_W-1:0] outstanding_q;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic             credit_ok;
  logic             push_data;
  logic             flush;
  logic             pop;
  logic             gnt_hs;
  logic [CNT_W-1:0] rvalid_dec;

  logic [ILEN-1:0]  d_rdata;
  logic             d_full, d_empty;
  logic [CNT_W-1:0] d_count;
  logic [XLEN-1:0]  t_rdata;
  logic             t_full, t_empty;
  logic [CNT_W-1:0] t_count;

  assign rvalid_dec = CNT_W'(i_imem_rvalid);
  assign credit_ok  = (SUM_W'(d_count) + SUM_W'(outstanding_q)) < SUM_W'(FIFO_DEPTH);

  // Next state, issue and response acceptance; redirect overrides everything.
  always_comb begin
    state_d    = state_q;
    o_imem_req = 1'b0;
    push_data  = 1'b0;
    flush      = 1'b0;
    drop_cnt_d = drop_cnt_q;
    case (state_q)
      IF_BOOT: begin
        state_d = IF_RUN;
      end
      IF_RUN: begin
        if (i_redirect) begin
          flush      = 1'b1;
          drop_cnt_d = outstanding_q - rvalid_dec;
          if (drop_cnt_d != '0) state_d = IF_FLUSH;
        end else begin
          o_imem_req = credit_ok;
          push_data  = i_imem_rvalid;
        end
      end
      IF_FLUSH: begin
        if (i_imem_rvalid) begin
          drop_cnt_d = drop_cnt_q - CNT_W'(1);
          if (drop_cnt_q == CNT_W'(1)) state_d = IF_RUN;
        end
      end
      default: begin
        state_d = IF_BOOT;
      end
    endcase
  end

  assign gnt_hs      = o_imem_req & i_imem_gnt;
  assign o_imem_addr = fetch_pc_q;
  assign o_valid     = !d_empty && (state_q == IF_RUN);
  assign o_instr     = d_empty ? NOP_INSTR : d_rdata;
  assign o_pc        = d_empty ? last_pc_q : t_rdata;
  assign pop         = o_valid && !i_stall && !i_redirect;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IF_BOOT;
    else        state_q <= state_d;
  end

  // PC, in-flight/drop counters and the PC shown while the buffer is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      last_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      drop_cnt_q    <= drop_cnt_d;
      outstanding_q <= outstanding_q + CNT_W'(gnt_hs) - rvalid_dec;
      if (i_redirect)  fetch_pc_q <= word_align(i_redirect_pc);
      else if (gnt_hs) fetch_pc_q <= fetch_pc_q + XLEN'(4);
      if (pop) last_pc_q <= t_rdata;
    end
  end

  ch0re_fetch_fifo #(.WIDTH(ILEN), .DEPTH(FIFO_DEPTH)) u_data_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_data),
    .wdata (i_imem_rdata),
    .pop   (pop),
    .flush (flush),
    .rdata (d_rdata),
    .full  (d_full),
    .empty (d_empty),
    .count (d_count)
  );

  // PC tags are pushed at grant so each response inherits its request address.
  ch0re_fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (gnt_hs),
    .wdata (fetch_pc_q),
    .pop   (pop),
    .flush (flush),
    .rdata (t_rdata),
    .full  (t_full),
    .empty (t_empty),
    .count (t_count)
  );

`ifdef CH0RE_IFETCH_PERF_EN
  logic dropped;
  assign dropped = i_imem_rvalid &&
                   ((state_q == IF_FLUSH) || ((state_q == IF_RUN) && i_redirect));

  // Event counters; both wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_perf_fetched <= '0;
      o_perf_flushed <= '0;
    end else begin
      o_perf_fetched <= o_perf_fetched + 32'(pop);
      o_perf_flushed <= o_perf_flushed + (flush ? 32'(d_count) : 32'd0) + 32'(dropped);
    end
  end
`endif

  a_rvalid_needs_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_imem_rvalid && (outstanding_q == '0)));
  a_tag_tracks_data: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == IF_FLUSH) ||
    (SUM_W'(t_count) == SUM_W'(d_count) + SUM_W'(outstanding_q)));
  a_tag_empty_implies_data_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(t_empty && !d_empty));
  a_no_grant_when_tag_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(t_full && gnt_hs));
  a_no_push_when_data_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(d_full && push_data && !pop));

endmodule

// File: tb/tb_ch0re_ifetch.sv
// Scoreboard bench for ch0re_ifetch: a bench-side memory model answers
// granted requests in order; expected {instr, pc} are queued at grant and
// compared when the decoder side pops.
module tb_ch0re_ifetch;
  import ch0re_ifetch_pkg::*;

  localparam logic [63:0] RST_PC = 64'h0;
  localparam int unsigned DEPTH  = 2;

  logic        clk;
  logic        rst_n;
  logic        o_imem_req;
  logic [63:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        i_stall;
  logic        i_redirect;
  logic [63:0] i_redirect_pc;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [63:0] o_pc;
`ifdef CH0RE_IFETCH_PERF_EN
  logic [31:0] o_perf_fetched;
  logic [31:0] o_perf_flushed;
`endif

  ch0re_ifetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH), .NOP_INSTR(32'h00000013)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .i_stall       (i_stall),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_valid       (o_valid),
    .o_instr       (o_instr),
    .o_pc          (o_pc)
`ifdef CH0RE_IFETCH_PERF_EN
    ,
    .o_perf_fetched(o_perf_fetched),
    .o_perf_flushed(o_perf_flushed)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } exp_t;

  typedef struct {
    logic [63:0] addr;
    int          rdy;
  } pend_t;

  exp_t        sb[$];
  pend_t       pend[$];
  int          cyc;
  int          last_rdy;
  int          last_gnt_cyc;
  int          first_gnt_cyc;
  int          first_val_cyc;
  int unsigned dmin;
  int unsigned dmax;
  logic [63:0] exp_pc;
  logic [63:0] held_addr;
  bit          held;
  longint unsigned exp_fetched;
  longint unsigned exp_flushed;
  int          n_checks;
  int          n_pass;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[33:2] ^ a[63:32] ^ 32'h9E37_79B9;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask

  // One clock: drive inputs after the falling edge, then observe and score.
  task automatic step(input bit g, input bit s, input bit r, input logic [63:0] rp);
    int    d;
    exp_t  e;
    pend_t p;
    @(negedge clk);
    cyc++;
    if (pend.size() > 0 && pend[0].rdy <= cyc) begin
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = 32'h0;
    end
    i_imem_gnt    = g;
    i_stall       = s;
    i_redirect    = r;
    i_redirect_pc = rp;
    #1;
    if (held && !r) begin
      check("req_hold", 64'(o_imem_req), 64'd1);
      check("addr_hold", o_imem_addr, held_addr);
    end
    if (o_valid && first_val_cyc < 0) first_val_cyc = cyc;
    if (r) begin
      check("redir_req", 64'(o_imem_req), 64'd0);
      exp_flushed += longint'(sb.size());
      sb.delete();
      exp_pc = rp & ~64'h3;
    end else if (o_valid && !s) begin
      if (sb.size() == 0) begin
        check("pop_extra", 64'(o_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        check("o_pc", o_pc, e.pc);
        check("o_instr", 64'(o_instr), 64'(e.instr));
        exp_fetched++;
      end
    end
    if (o_imem_req && g) begin
      check("req_addr", o_imem_addr, exp_pc);
      e.instr = mem_word(exp_pc);
      e.pc    = exp_pc;
      sb.push_back(e);
      d = cyc + 1 + int'($urandom_range(dmax, dmin));
      if (d < last_rdy) d = last_rdy;
      last_rdy = d;
      p.addr = exp_pc;
      p.rdy  = d;
      pend.push_back(p);
      exp_pc += 64'd4;
      if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
      last_gnt_cyc = cyc;
    end
    held      = o_imem_req && !g;
    held_addr = o_imem_addr;
  endtask

  task automatic drain(input int n, input string tag);
    repeat (n) step(1'b0, 1'b0, 1'b0, 64'h0);
    check({tag, "_valid"}, 64'(o_valid), 64'd0);
    check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
`ifdef CH0RE_IFETCH_PERF_EN
    check({tag, "_perf_fetched"}, 64'(o_perf_fetched), 64'(32'(exp_fetched)));
    check({tag, "_perf_flushed"}, 64'(o_perf_flushed), 64'(32'(exp_flushed)));
`endif
  endtask

  initial begin
    logic [31:0] hold_i;
    logic [63:0] hold_p;
    int          rc;
    bit          g, s, r;
    logic [63:0] rp;

    n_checks = 0; n_pass = 0; cyc = 0; last_rdy = 0;
    first_gnt_cyc = -1; first_val_cyc = -1; last_gnt_cyc = -1;
    dmin = 0; dmax = 0; exp_pc = RST_PC; held = 1'b0; held_addr = '0;
    exp_fetched = 0; exp_flushed = 0;
    rst_n = 1'b0; i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = '0;
    i_stall = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_req", 64'(o_imem_req), 64'd0);
    check("rst_addr", o_imem_addr, RST_PC);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_instr", 64'(o_instr), 64'(CH0RE_NOP));
    check("rst_pc", o_pc, RST_PC);

    // Release; cycle 0 is BOOT with no request
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    #1;
    check("boot_req", 64'(o_imem_req), 64'd0);

    // Grant always, 1-cycle read latency: sequential stream
    repeat (20) step(1'b1, 1'b0, 1'b0, 64'h0);
    check("first_gnt_cycle", 64'(first_gnt_cyc), 64'd1);
    check("first_valid_cycle", 64'(first_val_cyc), 64'd3);

    // Stall five cycles: output frozen, issue limited by credit
    step(1'b1, 1'b1, 1'b0, 64'h0);
    check("stall_valid", 64'(o_valid), 64'd1);
    hold_i = o_instr;
    hold_p = o_pc;
    repeat (4) begin
      step(1'b1, 1'b1, 1'b0, 64'h0);
      check("stall_instr", 64'(o_instr), 64'(hold_i));
      check("stall_pc", o_pc, hold_p);
    end
    check("stall_req_off", 64'(o_imem_req), 64'd0);
    check("stall_inflight", 64'(sb.size()), 64'(DEPTH));
    repeat (10) step(1'b1, 1'b0, 1'b0, 64'h0);
    drain(10, "d1");

    // Redirect to 0x1003 with two requests in flight
    dmin = 4; dmax = 4;
    step(1'b1, 1'b0, 1'b0, 64'h0);
    step(1'b1, 1'b0, 1'b0, 64'h0);
    check("inflight_two", 64'(sb.size()), 64'd2);
    step(1'b1, 1'b0, 1'b1, 64'h1003);
    rc = cyc;
    repeat (4) begin
      step(1'b1, 1'b0, 1'b0, 64'h0);
      check("flush_req", 64'(o_imem_req), 64'd0);
      check("flush_valid", 64'(o_valid), 64'd0);
    end
    dmin = 0; dmax = 0;
    step(1'b1, 1'b0, 1'b0, 64'h0);
    check("flush_regrant_cycle", 64'(last_gnt_cyc - rc), 64'd5);
    repeat (10) step(1'b1, 1'b0, 1'b0, 64'h0);
    drain(10, "d2");

    // Redirect coinciding with a response and an ungranted held request
    dmin = 2; dmax = 2;
    step(1'b1, 1'b0, 1'b0, 64'h0);
    step(1'b0, 1'b0, 1'b0, 64'h0);
    step(1'b0, 1'b0, 1'b0, 64'h0);
    check("held_req", 64'(o_imem_req), 64'd1);
    step(1'b0, 1'b0, 1'b1, 64'h2000);
    rc = cyc;
    dmin = 0; dmax = 0;
    step(1'b1, 1'b0, 1'b0, 64'h0);
    check("redir_regrant_cycle", 64'(last_gnt_cyc - rc), 64'd1);
    repeat (10) step(1'b1, 1'b0, 1'b0, 64'h0);
    drain(10, "d3");

    // Random grant, latency, stall and redirect traffic
    dmin = 0; dmax = 3;
    repeat (1500) begin
      g  = ($urandom % 3) != 0;
      s  = ($urandom % 4) == 0;
      r  = ($urandom % 50) == 0;
      rp = (($urandom % 4) == 0) ? 64'hFFFF_FFFF_FFFF_FFF5 : {$urandom, $urandom};
      step(g, s, r, rp);
    end
    drain(20, "d4");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
